// File: rtl/uart_frame_pkg.sv
// Shared state encoding and default framing bytes for the uart frame receiver.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    LEN    = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    COMMIT = 3'd5,
    RESP   = 3'd6
  } frame_state_t;

  localparam logic [7:0] SOF_DEF = 8'hA5;
  localparam logic [7:0] ACK_DEF = 8'h06;
  localparam logic [7:0] NAK_DEF = 8'h15;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one synchronous write port filled while parsing DATA bytes,
// one combinational read port walked during COMMIT.
module uart_frame_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Framed command receiver: SOF|ADDR|LEN|DATA[LEN]|CHK -> register writes + ACK/NAK.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN     = 8,
  parameter logic [7:0] SOF         = SOF_DEF,
  parameter logic [7:0] ACK         = ACK_DEF,
  parameter logic [7:0] NAK         = NAK_DEF,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_empty,
  input  logic [7:0] i_rd_data,
  output logic       o_rd_uart,
  input  logic       i_tx_full,
  output logic       o_wr_uart,
  output logic [7:0] o_wr_data,
  output logic       o_reg_we,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_busy,
  output logic       o_frame_err
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  frame_state_t     state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       resp_q, resp_d;
  logic             reg_we_q, reg_we_d;
  logic [7:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             wr_uart_q, wr_uart_d;
  logic             frame_err_q, frame_err_d;

  logic             pop;
  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic             tmo_hit;

  assign pop = !i_reset && !i_rx_empty &&
               (state_q inside {IDLE, ADDR, LEN, DATA, CHK});

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (i_clk),
    .we    (buf_we),
    .waddr (idx_q[AW-1:0]),
    .wdata (i_rd_data),
    .raddr (idx_q[AW-1:0]),
    .rdata (buf_rdata)
  );

`ifdef FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             waiting;

  // Counts consecutive stall cycles while a frame is partially received.
  assign waiting = (state_q inside {ADDR, LEN, DATA, CHK}) && !pop;
  assign tmo_hit = waiting && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (waiting && !tmo_hit) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  // No timeout: a stalled frame waits indefinitely for its next byte.
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    resp_d      = resp_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    wr_uart_d   = 1'b0;
    frame_err_d = 1'b0;
    buf_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pop && i_rd_data == SOF) state_d = ADDR;
      end
      ADDR: begin
        if (pop) begin
          addr_d  = i_rd_data;
          chk_d   = i_rd_data;
          state_d = LEN;
        end
      end
      LEN: begin
        if (pop) begin
          chk_d = chk_q ^ i_rd_data;
          if (i_rd_data == 8'd0 || i_rd_data > 8'(MAX_LEN)) begin
            frame_err_d = 1'b1;
            resp_d      = NAK;
            state_d     = RESP;
          end else begin
            len_d   = i_rd_data[IDX_W-1:0];
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (pop) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ i_rd_data;
          idx_d  = idx_q + ONE;
          if (idx_q == len_q - ONE) begin
            idx_d   = '0;
            state_d = CHK;
          end
        end
      end
      CHK: begin
        if (pop) begin
          if (i_rd_data == chk_q) begin
            state_d = COMMIT;
          end else begin
            frame_err_d = 1'b1;
            resp_d      = NAK;
            state_d     = RESP;
          end
        end
      end
      // idx is reused as the buffer read pointer while replaying writes.
      COMMIT: begin
        reg_we_d    = 1'b1;
        reg_addr_d  = addr_q + 8'(idx_q);
        reg_wdata_d = buf_rdata;
        idx_d       = idx_q + ONE;
        if (idx_q == len_q - ONE) begin
          idx_d   = '0;
          resp_d  = ACK;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!i_tx_full) begin
          wr_uart_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      frame_err_d = 1'b1;
      idx_d       = '0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      resp_q      <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      wr_uart_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      resp_q      <= resp_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      wr_uart_q   <= wr_uart_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_rd_uart   = pop;
  assign o_wr_uart   = wr_uart_q;
  assign o_wr_data   = resp_q;
  assign o_reg_we    = reg_we_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_reg_wdata = reg_wdata_q;
  assign o_busy      = (state_q != IDLE);
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a byte queue models the RX FIFO, a negedge
// monitor logs writes/pushes/errors, and a vector table holds expected results.
module tb_uart_frame_rx;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_empty = 1'b1;
  logic [7:0] i_rd_data = 8'h00;
  logic       i_tx_full = 1'b0;
  logic       o_rd_uart, o_wr_uart, o_reg_we, o_busy, o_frame_err;
  logic [7:0] o_wr_data, o_reg_addr, o_reg_wdata;

  uart_frame_rx dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx_empty  (i_rx_empty),
    .i_rd_data   (i_rd_data),
    .o_rd_uart   (o_rd_uart),
    .i_tx_full   (i_tx_full),
    .o_wr_uart   (o_wr_uart),
    .o_wr_data   (o_wr_data),
    .o_reg_we    (o_reg_we),
    .o_reg_addr  (o_reg_addr),
    .o_reg_wdata (o_reg_wdata),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    int               n;
    logic [11:0][7:0] b;
    int               full;
    int               nw;
    logic [7:0][7:0]  wa;
    logic [7:0][7:0]  wd;
    logic [7:0]       resp;
    int               nerr;
  } vec_t;

  vec_t vecs [6];

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo [$];
  logic       pop_seen = 1'b0;
  int         cyc = 0;
  int         last_pop = 0;
  int         w_cnt = 0;
  logic [7:0] w_addr [16];
  logic [7:0] w_data [16];
  int         w_cyc  [16];
  int         push_cnt = 0;
  logic [7:0] push_data = 8'h00;
  int         err_cnt = 0;

  // Monitor: outputs are stable at the falling edge.
  always @(negedge i_clk) begin
    cyc++;
    pop_seen = o_rd_uart;
    if (o_rd_uart) last_pop = cyc;
    if (o_reg_we && w_cnt < 16) begin
      w_addr[w_cnt] = o_reg_addr;
      w_data[w_cnt] = o_reg_wdata;
      w_cyc[w_cnt]  = cyc;
      w_cnt++;
    end
    if (o_wr_uart) begin
      push_cnt++;
      push_data = o_wr_data;
    end
    if (o_frame_err) err_cnt++;
  end

  // RX FIFO model: head advances just after the edge that popped it.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
      i_rx_empty = (fifo.size() == 0);
      i_rd_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    w_cnt = 0;
    push_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic run_frame(input vec_t v, input int id);
    int budget;
    clear_logs();
    for (int i = 0; i < v.n; i++) fifo.push_back(v.b[i]);
    if (v.full > 0) begin
      i_tx_full = 1'b1;
      repeat (v.n + v.nw + 4 + v.full) tick();
      check($sformatf("v%0d push_while_full", id), push_cnt, 0);
      i_tx_full = 1'b0;
    end
    budget = 0;
    while (push_cnt == 0 && budget < 200) begin
      tick();
      budget++;
    end
    if (push_cnt == 0) check($sformatf("v%0d resp_timeout", id), 0, 1);
    repeat (4) tick();
    check($sformatf("v%0d nwrites", id), w_cnt, v.nw);
    for (int i = 0; i < v.nw && i < w_cnt; i++) begin
      check($sformatf("v%0d waddr%0d", id, i), w_addr[i], v.wa[i]);
      check($sformatf("v%0d wdata%0d", id, i), w_data[i], v.wd[i]);
      check($sformatf("v%0d wcyc%0d", id, i), w_cyc[i] - w_cyc[0], i);
    end
    if (v.nw > 0 && w_cnt > 0)
      check($sformatf("v%0d first_write_latency", id), w_cyc[0] - last_pop, 2);
    check($sformatf("v%0d npush", id), push_cnt, 1);
    check($sformatf("v%0d push_byte", id), push_data, v.resp);
    check($sformatf("v%0d frame_err", id), err_cnt, v.nerr);
    check($sformatf("v%0d busy_end", id), o_busy, 0);
  endtask

  initial begin
    vecs[0] = '{n: 6, b: 96'({8'h21, 8'h22, 8'h11, 8'h02, 8'h10, 8'hA5}), full: 0,
                nw: 2, wa: 64'({8'h11, 8'h10}), wd: 64'({8'h22, 8'h11}), resp: 8'h06, nerr: 0};
    vecs[1] = '{n: 6, b: 96'({8'h20, 8'h22, 8'h11, 8'h02, 8'h10, 8'hA5}), full: 0,
                nw: 0, wa: 64'h0, wd: 64'h0, resp: 8'h15, nerr: 1};
    vecs[2] = '{n: 6, b: 96'({8'hEC, 8'hBB, 8'hAA, 8'h02, 8'hFF, 8'hA5}), full: 0,
                nw: 2, wa: 64'({8'h00, 8'hFF}), wd: 64'({8'hBB, 8'hAA}), resp: 8'h06, nerr: 0};
    vecs[3] = '{n: 5, b: 96'({8'h00, 8'h10, 8'hA5, 8'hFF, 8'h00}), full: 0,
                nw: 0, wa: 64'h0, wd: 64'h0, resp: 8'h15, nerr: 1};
    vecs[4] = vecs[0];
    vecs[5] = vecs[0];
    vecs[5].full = 10;

    i_reset = 1'b1;
    repeat (3) tick();
    check("rst rd_uart", o_rd_uart, 0);
    check("rst wr_uart", o_wr_uart, 0);
    check("rst wr_data", o_wr_data, 0);
    check("rst reg_we", o_reg_we, 0);
    check("rst reg_addr", o_reg_addr, 0);
    check("rst reg_wdata", o_reg_wdata, 0);
    check("rst busy", o_busy, 0);
    check("rst frame_err", o_frame_err, 0);
    i_reset = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) run_frame(vecs[k], k);

    // Reset in the middle of a payload must abort without writes or response.
    clear_logs();
    fifo.push_back(8'hA5);
    fifo.push_back(8'h10);
    fifo.push_back(8'h02);
    fifo.push_back(8'h11);
    repeat (8) tick();
    check("mid busy_before_reset", o_busy, 1);
    i_reset = 1'b1;
    repeat (2) tick();
    check("mid rst busy", o_busy, 0);
    check("mid rst reg_we", o_reg_we, 0);
    check("mid rst wr_uart", o_wr_uart, 0);
    i_reset = 1'b0;
    repeat (5) tick();
    check("mid writes", w_cnt, 0);
    check("mid pushes", push_cnt, 0);
    run_frame(vecs[0], 6);

`ifdef FRAME_TIMEOUT_EN
    clear_logs();
    fifo.push_back(8'hA5);
    fifo.push_back(8'h10);
    for (int i = 0; i < 5000 && err_cnt == 0; i++) tick();
    repeat (3) tick();
    check("tmo frame_err", err_cnt, 1);
    check("tmo pushes", push_cnt, 0);
    check("tmo busy", o_busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
